// File: rtl/seed_loader.sv
// seed_loader: accepts a ROWSxCOLS Game-of-Life seed one row per valid/ready beat,
// and commits it atomically to the seed bus. Define LFSR_SEED_EN to add the LFSR fill (GEN).
module seed_loader #(
  parameter int unsigned ROWS      = 32,
  parameter int unsigned COLS      = 32,
  parameter logic [31:0] LFSR_POLY = 32'h80200003,
  parameter logic [31:0] LFSR_INIT = 32'h00000001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  load_abort,
  input  logic                  gen_random,
  input  logic                  row_valid,
  input  logic [COLS-1:0]       row_data,
  output logic                  row_ready,
  output logic [$clog2(ROWS):0] row_count,
  output logic [ROWS*COLS-1:0]  seed,
  output logic                  seed_done,
  output logic                  gol_start
);
  localparam int AW = $clog2(ROWS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

`ifdef LFSR_SEED_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_GEN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0] shadow_q, shadow_d;
  logic [ROWS-1:0][COLS-1:0] seed_q, seed_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      start_q, start_d;
  logic                      wr_en, commit;
  logic [COLS-1:0]           wr_row;
  logic [AW-1:0]             wr_idx;

`ifdef LFSR_SEED_EN
  logic [31:0] lfsr_q, lfsr_d, lfsr_step;
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
`else
  logic unused_gen;
  assign unused_gen = gen_random ^ (^LFSR_POLY) ^ (^LFSR_INIT);
`endif

  // Ready depends only on FSM state and abort, never on row_valid.
  assign row_ready = (state_q == S_LOAD) & ~load_abort;
  assign wr_idx    = cnt_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    wr_en   = 1'b0;
    wr_row  = row_data;
    commit  = 1'b0;
`ifdef LFSR_SEED_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
`ifdef LFSR_SEED_EN
        else if (gen_random) begin
          state_d = S_GEN;
          cnt_d   = '0;
        end
`endif
      end
      S_LOAD: begin
        if (load_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (row_valid) begin
          wr_en = 1'b1;
        end
      end
`ifdef LFSR_SEED_EN
      S_GEN: begin
        if (load_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          wr_en  = 1'b1;
          wr_row = lfsr_q[COLS-1:0];
          lfsr_d = lfsr_step;
        end
      end
`endif
      S_COMMIT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Last row lands in the shadow and the seed in the same edge, so seed and
    // seed_done are visible in the COMMIT cycle.
    if (wr_en) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_ROW) begin
        state_d = S_COMMIT;
        commit  = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign shadow_d[r] = (wr_en && (wr_idx == AW'(r))) ? wr_row : shadow_q[r];
  end

  assign seed_d  = commit ? shadow_d : seed_q;
  assign done_d  = commit;
  assign start_d = (state_d == S_IDLE) & valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      seed_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
`ifdef LFSR_SEED_EN
      lfsr_q   <= LFSR_INIT;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seed_q   <= seed_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      start_q  <= start_d;
`ifdef LFSR_SEED_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign row_count = cnt_q;
  assign seed      = seed_q;
  assign seed_done = done_q;
  assign gol_start = start_q;

endmodule

// File: tb/tb_seed_loader.sv
// Directed bench for seed_loader: load, toggled-valid load, abort, abort+beat, reset mid-load,
// and (with LFSR_SEED_EN) the LFSR fill.
module tb_seed_loader;
  localparam int ROWS = 32;
  localparam int COLS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_req, load_abort, gen_random, row_valid;
  logic [COLS-1:0]  row_data;
  logic             row_ready;
  logic [5:0]       row_count;
  logic [1023:0]    seed;
  logic             seed_done, gol_start;

  int total = 0;
  int bad   = 0;
  logic [1023:0] diag, exp3;

  seed_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_abort(load_abort),
    .gen_random(gen_random), .row_valid(row_valid), .row_data(row_data),
    .row_ready(row_ready), .row_count(row_count), .seed(seed),
    .seed_done(seed_done), .gol_start(gol_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seed(input string tag, input logic [1023:0] exp);
    int r0;
    r0 = 0;
    total++;
    assert (seed === exp) else begin
      bad++;
      for (int r = ROWS - 1; r >= 0; r--)
        if (seed[r*COLS +: COLS] !== exp[r*COLS +: COLS]) r0 = r;
      $error("FAIL %s row %0d obs=%h exp=%h", tag, r0, seed[r0*COLS +: COLS], exp[r0*COLS +: COLS]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LFSR_SEED_EN
    logic [31:0]   lfsr_m;
    logic [1023:0] expg;
    int            n;
`endif
    reset = 1'b0; load_req = 1'b0; load_abort = 1'b0; gen_random = 1'b0;
    row_valid = 1'b0; row_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      diag[r*COLS +: COLS] = 32'(1) << r;
      exp3[r*COLS +: COLS] = 32'hFFFF_0000 ^ 32'(r);
    end

    // Reset state
    repeat (2) tick();
    chk("rst_done", seed_done, 1'b0);
    reset = 1'b1;
    tick();
    chk_seed("rst_seed", '0);
    chk("rst_done_rel", seed_done, 1'b0);
    chk("rst_start", gol_start, 1'b0);
    chk("rst_ready", row_ready, 1'b0);
    chk("rst_count", row_count, 6'd0);

    // Diagonal load, back-to-back beats
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("t2_ready", row_ready, 1'b1);
    chk("t2_start_low", gol_start, 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      row_valid = 1'b1;
      row_data  = 32'(1) << r;
      tick();
      if (r == 15) chk("t2_count16", row_count, 6'd16);
    end
    row_valid = 1'b0;
    chk_seed("t2_seed", diag);
    chk("t2_done", seed_done, 1'b1);
    chk("t2_start_commit", gol_start, 1'b0);
    tick();
    chk("t2_done_pulse", seed_done, 1'b0);
    chk("t2_start", gol_start, 1'b1);
    chk("t2_count0", row_count, 6'd0);

    // Abort after 10 rows; load_req during LOAD is ignored
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("t4_start_low", gol_start, 1'b0);
    for (int r = 0; r < 10; r++) begin
      row_valid = 1'b1;
      row_data  = 32'hA5A5_0000 | 32'(r);
      load_req  = (r == 3);
      tick();
    end
    load_req = 1'b0;
    row_valid = 1'b0;
    chk("t4_count10", row_count, 6'd10);
    load_abort = 1'b1;
    #1;
    chk("t4_ready_abort", row_ready, 1'b0);
    tick();
    load_abort = 1'b0;
    chk_seed("t4_seed", diag);
    chk("t4_done", seed_done, 1'b0);
    chk("t4_start", gol_start, 1'b1);
    chk("t4_count", row_count, 6'd0);

    // Abort with a beat presented at row 5
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int r = 0; r < 5; r++) begin
      row_valid = 1'b1;
      row_data  = 32'hFFFF_FFFF;
      tick();
    end
    load_abort = 1'b1;
    row_valid  = 1'b1;
    #1;
    chk("t5_ready", row_ready, 1'b0);
    chk("t5_count5", row_count, 6'd5);
    tick();
    load_abort = 1'b0;
    chk("t5_idle_ready", row_ready, 1'b0);
    chk("t5_idle_start", gol_start, 1'b1);
    chk("t5_count0", row_count, 6'd0);
    row_valid = 1'b0;
    chk_seed("t5_seed", diag);

    // Load with row_valid toggling every other cycle
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      row_valid = 1'b1;
      row_data  = 32'hFFFF_0000 ^ 32'(r);
      tick();
      if (r != ROWS - 1) begin
        chk("t3_count_beat", row_count, 6'(r + 1));
        row_valid = 1'b0;
        row_data  = 32'hDEAD_BEEF;
        tick();
        chk("t3_count_idle", row_count, 6'(r + 1));
      end
    end
    row_valid = 1'b0;
    chk_seed("t3_seed", exp3);
    chk("t3_done", seed_done, 1'b1);
    tick();
    chk("t3_start", gol_start, 1'b1);

    // Asynchronous reset mid-load
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int r = 0; r < 3; r++) begin
      row_valid = 1'b1;
      row_data  = 32'h1234_5678;
      tick();
    end
    row_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_seed("rml_seed", '0);
    chk("rml_count", row_count, 6'd0);
    chk("rml_start", gol_start, 1'b0);
    chk("rml_ready", row_ready, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("rml_start_after", gol_start, 1'b0);

`ifdef LFSR_SEED_EN
    // LFSR fill: two successive fills from one free-running LFSR
    lfsr_m = 32'h0000_0001;
    for (int fill = 0; fill < 2; fill++) begin
      for (int r = 0; r < ROWS; r++) begin
        expg[r*COLS +: COLS] = lfsr_m;
        lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 32'h8020_0003) : (lfsr_m >> 1);
      end
      gen_random = 1'b1;
      tick();
      gen_random = 1'b0;
      n = 1;
      while (!seed_done && n < 40) begin
        tick();
        n++;
      end
      chk("t6_latency", 64'(n), 64'd33);
      if (fill == 0) begin
        chk("t6_row0", seed[31:0], 32'h0000_0001);
        chk("t6_row1", seed[63:32], 32'h8020_0003);
      end
      chk_seed("t6_seed", expg);
      tick();
      chk("t6_start", gol_start, 1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
